// File: rtl/msr_trap_ctrl.sv
// Sequencer/arbiter sharing the single-read/single-write MSR file between CSR
// accesses, trap entry (save mepc/mcause, update mstatus, vector) and MRET.
module msr_trap_ctrl #(
  parameter logic [3:0] MSTATUS_IDX = 4'd1,
  parameter logic [3:0] MTVEC_IDX   = 4'd2,
  parameter logic [3:0] MEPC_IDX    = 4'd3,
  parameter logic [3:0] MCAUSE_IDX  = 4'd4
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_trap_req,
  input  logic [31:0] I_trap_pc,
  input  logic [31:0] I_trap_cause,
  input  logic        I_mret_req,
  input  logic        I_csr_req,
  input  logic        I_csr_we,
  input  logic [3:0]  I_csr_addr,
  input  logic [31:0] I_csr_wdata,
  output logic        O_csr_ack,
  output logic [31:0] O_csr_rdata,
  output logic        O_redirect_valid,
  output logic [31:0] O_redirect_pc,
  output logic        O_busy,
  output logic [3:0]  O_msr_rs,
  input  logic [31:0] I_msr_rdata,
  output logic        O_msr_regwen,
  output logic [3:0]  O_msr_rd,
  output logic [31:0] O_msr_wdata
);

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_SRD,
    S_T_SWR,
    S_T_VEC,
    S_M_SRD,
    S_M_SWR,
    S_M_EPC,
    S_C_ACC
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] status_q;
  logic [3:0]  csr_addr_q;
  logic        csr_we_q;
  logic [31:0] csr_wdata_q;

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      status_q    <= '0;
      csr_addr_q  <= '0;
      csr_we_q    <= 1'b0;
      csr_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_trap_req) begin
            pc_q    <= I_trap_pc;
            cause_q <= I_trap_cause;
            state   <= S_T_EPC;
          end else if (I_mret_req) begin
            state <= S_M_SRD;
          end else if (I_csr_req) begin
            csr_addr_q  <= I_csr_addr;
            csr_we_q    <= I_csr_we;
            csr_wdata_q <= I_csr_wdata;
            state       <= S_C_ACC;
          end
        end
        S_T_EPC:   state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_SRD;
        S_T_SRD: begin
          status_q <= I_msr_rdata;
          state    <= S_T_SWR;
        end
        S_T_SWR:   state <= S_T_VEC;
        S_T_VEC:   state <= S_IDLE;
        S_M_SRD: begin
          status_q <= I_msr_rdata;
          state    <= S_M_SWR;
        end
        S_M_SWR:   state <= S_M_EPC;
        S_M_EPC:   state <= S_IDLE;
        S_C_ACC:   state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_csr_ack        = 1'b0;
    O_csr_rdata      = '0;
    O_redirect_valid = 1'b0;
    O_redirect_pc    = '0;
    O_busy           = (state != S_IDLE);
    O_msr_rs         = '0;
    O_msr_regwen     = 1'b0;
    O_msr_rd         = '0;
    O_msr_wdata      = '0;
    case (state)
      S_T_EPC: begin
        O_msr_regwen = 1'b1;
        O_msr_rd     = MEPC_IDX;
        O_msr_wdata  = pc_q;
      end
      S_T_CAUSE: begin
        O_msr_regwen = 1'b1;
        O_msr_rd     = MCAUSE_IDX;
        O_msr_wdata  = cause_q;
      end
      S_T_SRD: O_msr_rs = MSTATUS_IDX;
      S_T_SWR: begin
        O_msr_regwen          = 1'b1;
        O_msr_rd              = MSTATUS_IDX;
        O_msr_wdata           = status_q;
        O_msr_wdata[MPIE_BIT] = status_q[MIE_BIT];
        O_msr_wdata[MIE_BIT]  = 1'b0;
      end
      S_T_VEC: begin
        O_msr_rs         = MTVEC_IDX;
        O_redirect_valid = 1'b1;
        O_redirect_pc    = {I_msr_rdata[31:2], 2'b00};
      end
      S_M_SRD: O_msr_rs = MSTATUS_IDX;
      S_M_SWR: begin
        O_msr_regwen          = 1'b1;
        O_msr_rd              = MSTATUS_IDX;
        O_msr_wdata           = status_q;
        O_msr_wdata[MIE_BIT]  = status_q[MPIE_BIT];
        O_msr_wdata[MPIE_BIT] = 1'b1;
      end
      S_M_EPC: begin
        O_msr_rs         = MEPC_IDX;
        O_redirect_valid = 1'b1;
        O_redirect_pc    = {I_msr_rdata[31:2], 2'b00};
      end
      S_C_ACC: begin
        // index 0 reads as zero and never takes a write
        O_msr_rs     = csr_addr_q;
        O_csr_ack    = 1'b1;
        O_csr_rdata  = (csr_addr_q == 4'd0) ? '0 : I_msr_rdata;
        O_msr_regwen = csr_we_q && (csr_addr_q != 4'd0);
        O_msr_rd     = csr_addr_q;
        O_msr_wdata  = csr_wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msr_trap_ctrl.sv
// Scoreboard bench for msr_trap_ctrl with a behavioural MSR file attached.
module tb_msr_trap_ctrl;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_req;
  logic        csr_req;
  logic        csr_we;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [3:0]  msr_rs;
  logic [31:0] msr_rdata;
  logic        msr_regwen;
  logic [3:0]  msr_rd;
  logic [31:0] msr_wdata;

  logic [31:0] msr_mem [16];
  logic        mem_clr;
  logic [31:0] cyc = '0;
  logic [31:0] shadow [16];

  exp_t csr_q [$];
  exp_t rd_q  [$];
  exp_t wr_q  [$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  msr_trap_ctrl #(
    .MSTATUS_IDX(4'd1),
    .MTVEC_IDX  (4'd2),
    .MEPC_IDX   (4'd3),
    .MCAUSE_IDX (4'd4)
  ) dut (
    .I_clk           (clk),
    .I_rstn          (rstn),
    .I_trap_req      (trap_req),
    .I_trap_pc       (trap_pc),
    .I_trap_cause    (trap_cause),
    .I_mret_req      (mret_req),
    .I_csr_req       (csr_req),
    .I_csr_we        (csr_we),
    .I_csr_addr      (csr_addr),
    .I_csr_wdata     (csr_wdata),
    .O_csr_ack       (csr_ack),
    .O_csr_rdata     (csr_rdata),
    .O_redirect_valid(redirect_valid),
    .O_redirect_pc   (redirect_pc),
    .O_busy          (busy),
    .O_msr_rs        (msr_rs),
    .I_msr_rdata     (msr_rdata),
    .O_msr_regwen    (msr_regwen),
    .O_msr_rd        (msr_rd),
    .O_msr_wdata     (msr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 32'd1;

  // MSR file: index 0 holds junk so the controller's zero-forcing is observable
  assign msr_rdata = (msr_rs == 4'd0) ? 32'hDEAD_BEEF : msr_mem[msr_rs];
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) msr_mem[i] <= '0;
    end else if (msr_regwen) begin
      msr_mem[msr_rd] <= msr_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [3:0] idx, input logic [31:0] data, input logic [31:0] c);
    exp_t e;
    e.idx = idx; e.data = data; e.cyc = c;
    wr_q.push_back(e);
    shadow[idx] = data;
  endtask

  task automatic push_rd(input logic [31:0] pc, input logic [31:0] c);
    exp_t e;
    e.idx = '0; e.data = pc & 32'hFFFF_FFFC; e.cyc = c;
    rd_q.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] k, input logic [31:0] pc, input logic [31:0] cause,
                           input bit full);
    logic [31:0] ns;
    push_wr(4'd3, pc, k + 1);
    push_wr(4'd4, cause, k + 2);
    if (full) begin
      ns = shadow[1];
      ns[7] = ns[3];
      ns[3] = 1'b0;
      push_wr(4'd1, ns, k + 4);
      push_rd(shadow[2], k + 5);
    end
  endtask

  task automatic push_mret(input logic [31:0] k);
    logic [31:0] ns;
    ns = shadow[1];
    ns[3] = ns[7];
    ns[7] = 1'b1;
    push_wr(4'd1, ns, k + 2);
    push_rd(shadow[3], k + 3);
  endtask

  task automatic push_csr(input logic [3:0] a, input logic we, input logic [31:0] d,
                          input logic [31:0] c);
    exp_t e;
    e.idx = a; e.data = (a == 4'd0) ? 32'd0 : shadow[a]; e.cyc = c;
    csr_q.push_back(e);
    if (we && a != 4'd0) push_wr(a, d, c);
  endtask

  task automatic csr_xfer(input logic [3:0] a, input logic we, input logic [31:0] d);
    bit seen;
    sync();
    push_csr(a, we, d, cyc + 1);
    csr_req = 1'b1; csr_we = we; csr_addr = a; csr_wdata = d;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = csr_ack;
    end
    check("csr_ack_seen", 32'(seen), 1);
    sync();
    csr_req = 1'b0; csr_we = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("idle_reached", 32'(idle), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 32'({csr_ack, redirect_valid, busy, msr_regwen, msr_rs, msr_rd}), 0);
    check({tag, "_rdata"}, csr_rdata, 0);
    check({tag, "_rpc"}, redirect_pc, 0);
    check({tag, "_wdata"}, msr_wdata, 0);
  endtask

  // Monitor: every DUT output event must match the head of its queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (csr_ack) begin
          if (csr_q.size() == 0) check("csr_unexpected", 32'(csr_ack), 0);
          else begin
            e = csr_q.pop_front();
            check("csr_rdata", csr_rdata, e.data);
            check("csr_cycle", cyc, e.cyc);
          end
        end
        if (redirect_valid) begin
          if (rd_q.size() == 0) check("redir_unexpected", 32'(redirect_valid), 0);
          else begin
            e = rd_q.pop_front();
            check("redir_pc", redirect_pc, e.data);
            check("redir_cycle", cyc, e.cyc);
          end
        end
        if (msr_regwen) begin
          if (wr_q.size() == 0) check("wr_unexpected", 32'(msr_regwen), 0);
          else begin
            e = wr_q.pop_front();
            check("wr_idx", 32'(msr_rd), 32'(e.idx));
            check("wr_data", msr_wdata, e.data);
            check("wr_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] k;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    rstn = 1'b0; mem_clr = 1'b1;
    trap_req = 1'b1; trap_pc = 32'h44; trap_cause = 32'h1; mret_req = 1'b0;
    csr_req = 1'b1; csr_we = 1'b1; csr_addr = 4'd2; csr_wdata = 32'h55;

    // Reset holds everything at zero even with requests pending
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    trap_req = 1'b0; csr_req = 1'b0; csr_we = 1'b0;
    @(negedge clk);
    rstn = 1'b1; mem_clr = 1'b0;
    sync();
    check_outputs_zero("idle");

    // 1: CSR write then read of mtvec
    csr_xfer(4'd2, 1'b1, 32'h0000_0103);
    csr_xfer(4'd2, 1'b0, 32'h0);
    check("t1_mtvec", msr_mem[2], 32'h103);

    // 2: trap entry
    csr_xfer(4'd1, 1'b1, 32'h8);
    sync(); k = cyc;
    push_trap(k, 32'h40, 32'h8000_000B, 1'b1);
    trap_req = 1'b1; trap_pc = 32'h40; trap_cause = 32'h8000_000B;
    sync(); trap_req = 1'b0;
    wait_idle();
    check("t2_mepc", msr_mem[3], 32'h40);
    check("t2_mcause", msr_mem[4], 32'h8000_000B);
    check("t2_mstatus", msr_mem[1], 32'h80);

    // 3: MRET
    sync(); k = cyc;
    push_mret(k);
    mret_req = 1'b1;
    sync(); mret_req = 1'b0;
    wait_idle();
    check("t3_mstatus", msr_mem[1], 32'h88);

    // 4: trap and CSR on the same edge; trap wins, CSR follows on cycle 7
    sync(); k = cyc;
    push_trap(k, 32'h300, 32'h2, 1'b1);
    push_csr(4'd4, 1'b0, 32'h0, k + 7);
    trap_req = 1'b1; trap_pc = 32'h300; trap_cause = 32'h2;
    csr_req = 1'b1; csr_we = 1'b0; csr_addr = 4'd4; csr_wdata = 32'h0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) trap_req = 1'b0;
      @(negedge clk);
      if (i == 6) check("t4_gap_idle", 32'(busy), 0);
      else check("t4_busy", 32'(busy), 1);
    end
    sync(); csr_req = 1'b0;
    wait_idle();

    // 5: reset in T_SWR abandons the sequence before the mstatus write
    csr_xfer(4'd1, 1'b1, 32'h8);
    sync(); k = cyc;
    push_trap(k, 32'h200, 32'h5, 1'b0);
    trap_req = 1'b1; trap_pc = 32'h200; trap_cause = 32'h5;
    sync(); trap_req = 1'b0;
    while (cyc < k + 4) sync();
    #1 rstn = 1'b0;
    #1 check_outputs_zero("t5_abort");
    sync(); sync();
    check("t5_mstatus", msr_mem[1], 32'h8);
    check("t5_mepc", msr_mem[3], 32'h200);
    @(negedge clk) rstn = 1'b1;
    csr_xfer(4'd1, 1'b0, 32'h0);

    // 6: index 0 hardwired, low redirect bits cleared, trap while busy ignored
    csr_xfer(4'd0, 1'b1, 32'hFFFF_FFFF);
    csr_xfer(4'd0, 1'b0, 32'h0);
    csr_xfer(4'd3, 1'b1, 32'h207);
    sync(); k = cyc;
    push_mret(k);
    mret_req = 1'b1;
    sync(); mret_req = 1'b0;
    trap_req = 1'b1; trap_pc = 32'h999; trap_cause = 32'h7;
    check("t6_busy", 32'(busy), 1);
    sync(); trap_req = 1'b0;
    wait_idle();
    repeat (4) sync();
    check("t6_mepc", msr_mem[3], 32'h207);
    check("t6_mstatus", msr_mem[1], 32'h80);

    check("csr_q_left", 32'(csr_q.size()), 0);
    check("rd_q_left", 32'(rd_q.size()), 0);
    check("wr_q_left", 32'(wr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
